seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexing scan controller for the Basys3 4-digit common-anode 7-segment display.
- Holds a 16-bit display word (4 hex nibbles) and sequences one nibble at a time into the existing combinational hex-to-segment decoder.
- Registers the decoder result, drives the anodes, and inserts a blanking gap at each digit change to prevent ghosting.
- New display words arrive through a valid/ready handshake and take effect only at frame boundaries, so no tearing occurs.

Parameters:
- SCAN_DIV, 100000: clk cycles per digit slot (100 MHz -> 1 kHz per digit, 250 Hz frame). Must be > BLANK_CYC.
- BLANK_CYC, 16: cycles at the start of each slot with all anodes off and segments off. Must be >= 1.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = scan running; 0 = display dark, scan held
- load_valid  input  1  new display word offered
- load_ready  output  1  controller can accept a word
- load_data  input  16  digit3..digit0 = [15:12]..[3:0]
- dec_nibble  output  4  nibble presented to the external decoder
- dec_seg  input  7  decoder result, active-low, bit6 = a ... bit0 = g
- seg_out  output  7  segment drive, active-low, abcdefg
- an_out  output  4  anode drive, active-low, bit i = digit i
- frame_tick  output  1  one-cycle pulse at each digit3 -> digit0 wrap

Behaviour:
- Reset values: seg_out = 7'b1111111, an_out = 4'b1111, frame_tick = 0, load_ready = 1. Internal state: cnt = 0, idx = 0, disp = 16'h0000, shadow = 0, pending = 0.
- cnt counts 0..SCAN_DIV-1 per slot; its width is $clog2(SCAN_DIV).
- At cnt == SCAN_DIV-1: cnt -> 0 and idx -> (idx+1) mod 4.
- When idx wraps from 3 to 0, frame_tick = 1 for exactly that cycle.
- dec_nibble = disp[4*idx +: 4], combinational from registers.
- Two-state FSM, derived from cnt:
  - BLANK while cnt < BLANK_CYC: next an_out = 4'b1111, next seg_out = 7'b1111111.
  - SHOW otherwise: next an_out = ~(4'b0001 << idx), next seg_out = dec_seg.
- Outputs are registered, giving one cycle of latency from dec_nibble to seg_out. The first SHOW cycle of a slot is therefore the first cycle the anode is on, and it shows the correct digit.
- Handshake:
  - load_ready = !pending.
  - Transfer occurs when load_valid && load_ready: shadow <= load_data, pending <= 1.
  - load_data is ignored while load_ready = 0; the producer must hold its word until ready.
- Commit:
  - In the wrap cycle, if pending: disp <= shadow, pending <= 0. load_ready rises the next cycle.
  - If a transfer and a wrap occur in the same cycle, the transferred word commits at the following wrap, not this one.
- enable = 0:
  - cnt, idx and frame_tick forced to 0.
  - Outputs go dark (BLANK values) on the next cycle.
  - Handshake still operates. A pending word commits on the first cycle enable is low, or on the cycle it arrives, with pending cleared the next cycle.
- enable rising: scanning restarts at idx 0, cnt 0, in BLANK.
- Reset mid-frame: all registers return to reset values on the next edge, a pending word is discarded, and outputs are dark.
- Only one anode is ever low. an_out = 4'b1111 whenever seg_out = 7'b1111111 is driven by BLANK.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: in SHOW, digit idx is suppressed (an_out = 4'b1111, seg_out = 7'b1111111) when idx > 0 and all nibbles from idx up to 3 are zero. Digit0 always shows. Example: disp = 16'h0042 lights only digits 1 and 0.
- Undefined: all four digits always show, including leading zeros.

Test Plan:
- Bench uses SCAN_DIV = 8, BLANK_CYC = 2, and the team's hex decoder on dec_nibble/dec_seg.
- Reset -> seg_out = 7'b1111111, an_out = 4'b1111, load_ready = 1, frame_tick = 0. enable = 1 with disp = 0 -> every slot shows 7'b0000001 at cnt 2..7.
- Load 16'h1234, then wait for the wrap -> next frame:
  - slot0: an_out = 1110, seg_out = 1001100
  - slot1: an_out = 1101, seg_out = 0000110
  - slot2: an_out = 1011, seg_out = 0010010
  - slot3: an_out = 0111, seg_out = 1001111
  - each slot dark for 2 cycles first; frame_tick pulses every 32 cycles.
- Second load_valid asserted while pending -> load_ready = 0, that word is not captured. Ready returns the cycle after the wrap, then the word is accepted. Displayed value changes only at frame boundaries.
- Transfer of 16'hABCD in the same cycle as a wrap -> the current frame keeps the old word; 16'hABCD appears from the next frame.
- Drop enable mid-slot2 -> dark the next cycle and a pending word commits. Re-enable -> scan restarts at digit0 in BLANK.
- Assert reset mid-frame with a word pending -> all outputs at reset values the next cycle, disp = 0, pending cleared.
- With SEG_LEADING_ZERO_BLANK_EN, load 16'h0042 -> slots 3 and 2 dark; slot1 shows 1001100, slot0 shows 0010010.

Source files
------------

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
// Time-multiplexing scan controller for a 4-digit common-anode 7-segment display.
// It holds a 16-bit display word and presents one nibble at a time to an external
// hex-to-segment decoder. It registers the decoder result and drives the anodes.
// A blanking gap at the start of every digit slot prevents ghosting. New words
// arrive over valid/ready and are committed only at frame boundaries.
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to suppress leading-zero
// digits. Digit0 is always shown.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   enable      1 = scan running, 0 = display dark and scan held at digit0
//   load_valid  new display word offered
//   load_ready  controller can accept a word (no word pending)
//   load_data   display word, digit3..digit0 = [15:12]..[3:0]
//   dec_nibble  nibble presented to the decoder (combinational from registers)
//   dec_seg     decoder result, active-low, bit6 = a ... bit0 = g
//   seg_out     segment drive, active-low, abcdefg
//   an_out      anode drive, active-low, bit i = digit i
//   frame_tick  one-cycle pulse when the scan wraps from digit3 to digit0
module seg_scan_controller #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    output logic [3:0]  dec_nibble,
    input  logic [6:0]  dec_seg,
    output logic [6:0]  seg_out,
    output logic [3:0]  an_out,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [1:0]       idx, idx_next;
    logic [15:0]      disp, disp_next;
    logic [15:0]      shadow, shadow_next;
    logic             pending, pending_next;
    logic [6:0]       seg_next;
    logic [3:0]       an_next;
    logic             tick_next;
    logic             slot_end;
    logic             wrap;
    logic             xfer;
    logic             lead_zero;

    // Current digit's nibble goes straight to the external decoder.
    assign dec_nibble = disp[{idx, 2'b00} +: 4];

    assign slot_end = (cnt == CNT_MAX);
    assign wrap     = enable && slot_end && (idx == 2'd3);
    assign xfer     = load_valid && !pending;

    // Digit idx is a leading zero when it and every higher nibble are zero.
    always_comb begin
        lead_zero = 1'b0;
        unique case (idx)
            2'd3:    lead_zero = (disp[15:12] == 4'h0);
            2'd2:    lead_zero = (disp[15:8] == 8'h00);
            2'd1:    lead_zero = (disp[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end

    // Next-state, handshake, commit and output decode.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        idx_next     = idx;
        disp_next    = disp;
        shadow_next  = shadow;
        pending_next = pending;
        seg_next     = 7'b1111111;
        an_next      = 4'b1111;
        tick_next    = wrap;

        // Slot counter and digit index; held at digit0/cnt0 while disabled.
        if (!enable) begin
            cnt_next = '0;
            idx_next = 2'd0;
        end else if (slot_end) begin
            cnt_next = '0;
            idx_next = idx + 2'd1;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end

        if (xfer) begin
            shadow_next  = load_data;
            pending_next = 1'b1;
        end

        // Commit at a frame wrap, or immediately while the display is dark.
        // A word arriving while disabled is shown at once; pending drops a cycle later.
        if (pending && (wrap || !enable)) begin
            disp_next    = shadow;
            pending_next = 1'b0;
        end else if (xfer && !enable) begin
            disp_next = load_data;
        end

        // State tracks the phase of cnt_next so the outputs land in step with it.
        unique case (state)
            ST_BLANK: if (enable && (cnt_next >= BLANK_END)) state_next = ST_SHOW;
            ST_SHOW:  if (!enable || (cnt_next == '0)) state_next = ST_BLANK;
            default:  state_next = ST_BLANK;
        endcase

        if (state_next == ST_SHOW) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = dec_seg;
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (lead_zero) begin
                an_next  = 4'b1111;
                seg_next = 7'b1111111;
            end
`endif
        end
    end

    // Status registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= 2'd0;
            disp       <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            seg_out    <= 7'b1111111;
            an_out     <= 4'b1111;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            idx        <= idx_next;
            disp       <= disp_next;
            shadow     <= shadow_next;
            pending    <= pending_next;
            load_ready <= !pending_next;
            seg_out    <= seg_next;
            an_out     <= an_next;
            frame_tick <= tick_next;
        end
    end

    // Only consumed when the leading-zero option is built in.
    logic unused_ok;
    assign unused_ok = lead_zero;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with SCAN_DIV = 8, BLANK_CYC = 2.
// A behavioural hex decoder sits on dec_nibble/dec_seg. The expected
// {frame_tick, an_out, seg_out} for each cycle of a frame is queued.
// Entries are popped and compared at the falling edge.
module tb_seg_scan_controller;

    localparam int unsigned SCAN_DIV  = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned FRAME     = 4 * SCAN_DIV;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       ft;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  dec_nibble;
    logic [6:0]  dec_seg;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    seg_scan_controller #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .dec_nibble (dec_nibble),
        .dec_seg    (dec_seg),
        .seg_out    (seg_out),
        .an_out     (an_out),
        .frame_tick (frame_tick)
    );

    // Active-low abcdefg hex decoder, bit6 = a.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    always_comb dec_seg = hex7(dec_nibble);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // Queue a full frame of expected outputs for 'word', then compare cycle by cycle.
    // Entry starts at the cycle with cnt = 0, idx = 0. The task returns at the
    // next frame's first cycle. load_valid is dropped after the first cycle.
    task automatic check_frame(input logic [15:0] word, input logic ft0);
        for (int k = 0; k < int'(FRAME); k++) begin
            int   s;
            int   c;
            exp_t e;
            s = k / int'(SCAN_DIV);
            c = k % int'(SCAN_DIV);
            e.ft = (k == 0) ? ft0 : 1'b0;
            if (c < int'(BLANK_CYC) || (LZ_EN && s > 0 && ((word >> (4 * s)) == 16'h0))) begin
                e.an  = 4'b1111;
                e.seg = 7'b1111111;
            end else begin
                e.an  = ~4'(4'b0001 << s);
                e.seg = hex7(word[4 * s +: 4]);
            end
            q.push_back(e);
        end
        for (int k = 0; k < int'(FRAME); k++) begin
            exp_t e;
            exp_t o;
            e = q.pop_front();
            o = {frame_tick, an_out, seg_out};
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL frame_%h_k%0d got ft/an/seg=%b/%b/%b want %b/%b/%b",
                       word, k, o.ft, o.an, o.seg, e.ft, e.an, e.seg);
            end
            @(negedge clk);
            if (k == 0) load_valid = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        reset      = 1'b1;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_seg", 16'(seg_out), 16'h007F);
        chk("rst_an", 16'(an_out), 16'h000F);
        chk("rst_ready", 16'(load_ready), 16'h0001);
        chk("rst_tick", 16'(frame_tick), 16'h0000);
        chk("rst_nibble", 16'(dec_nibble), 16'h0000);

        // Scan starts with the reset word of zero.
        reset  = 1'b0;
        enable = 1'b1;
        check_frame(16'h0000, 1'b0);

        // Load 1234, then offer 5678 while it is pending.
        load_valid = 1'b1;
        load_data  = 16'h1234;
        @(negedge clk);
        chk("busy_ready", 16'(load_ready), 16'h0000);
        load_data = 16'h5678;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (load_ready) seen = 1'b1;
        end
        chk("ready_return", 16'(seen), 16'h0001);
        chk("ready_at_tick", 16'(frame_tick), 16'h0001);
        check_frame(16'h1234, 1'b1);
        check_frame(16'h5678, 1'b1);
        chk("idle_ready", 16'(load_ready), 16'h0001);

        // Transfer ABCD in the wrap cycle: it shows one frame later.
        repeat (int'(FRAME) - 1) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'hABCD;
        @(negedge clk);
        chk("wrap_xfer_pending", 16'(load_ready), 16'h0000);
        check_frame(16'h5678, 1'b1);
        check_frame(16'hABCD, 1'b1);

        // Drop enable in slot2 with 0F0F pending.
        load_valid = 1'b1;
        load_data  = 16'h0F0F;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (2 * int'(SCAN_DIV) + 2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_an", 16'(an_out), 16'h000F);
        chk("dis_seg", 16'(seg_out), 16'h007F);
        chk("dis_tick", 16'(frame_tick), 16'h0000);
        chk("dis_ready", 16'(load_ready), 16'h0001);
        chk("dis_commit", 16'(dec_nibble), 16'h000F);
        repeat (3) @(negedge clk);
        chk("dis_hold_an", 16'(an_out), 16'h000F);
        chk("dis_hold_seg", 16'(seg_out), 16'h007F);
        enable = 1'b1;
        check_frame(16'h0F0F, 1'b0);

        // Reset mid-frame with 9999 pending.
        repeat (int'(SCAN_DIV) + 4) @(negedge clk);
        load_valid = 1'b1;
        load_data  = 16'h9999;
        @(negedge clk);
        load_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        chk("mid_rst_seg", 16'(seg_out), 16'h007F);
        chk("mid_rst_an", 16'(an_out), 16'h000F);
        chk("mid_rst_ready", 16'(load_ready), 16'h0001);
        chk("mid_rst_tick", 16'(frame_tick), 16'h0000);
        chk("mid_rst_disp", 16'(dec_nibble), 16'h0000);
        reset = 1'b0;
        check_frame(16'h0000, 1'b0);
        check_frame(16'h0000, 1'b1);

        // Word with leading zeros.
        load_valid = 1'b1;
        load_data  = 16'h0042;
        check_frame(16'h0000, 1'b1);
        check_frame(16'h0042, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
